// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type and default widths for pipe_stage_reg
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_CTRL_W = 10;
  localparam int PIPE_DATA_W = 197;
  localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter, cleared only by reset
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and stall counter
// PIPE_SKID_EN selects the fully registered two-entry skid build.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e state;
  logic        in_hs;
  logic        out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
`ifdef PIPE_SKID_EN
      in_ready  <= 1'b1;
      skid_ctrl <= '0;
      skid_data <= '0;
`endif
    end else if (flush) begin
      // Payload is left as-is; only control must never leak out of a killed stage.
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_ctrl  <= '0;
`ifdef PIPE_SKID_EN
      in_ready  <= 1'b1;
      skid_ctrl <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_hs) begin
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
`ifdef PIPE_SKID_EN
          if (in_hs && !out_hs) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else
`endif
          if (in_hs) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            state     <= EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (out_hs) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
`endif
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table plus scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 32;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  int vecs = 0;
  int errs = 0;
  logic [CW+DW-1:0] sb[$];

  typedef struct {
    logic          iv;
    logic          ordy;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          exp_ir;
    logic          exp_ov;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = c;
    in_data   = d;
  endtask

  // Scoreboard: pop on out handshake, then apply flush/push for the coming edge.
  always @(negedge clk) begin
    logic [CW+DW-1:0] exp_beat;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {22'd0, out_ctrl, out_data}, 64'd0);
        end else begin
          exp_beat = sb.pop_front();
          chk("beat", {22'd0, out_ctrl, out_data}, {22'd0, exp_beat});
        end
      end
      if (!out_valid) chk("bubble_ctrl", {54'd0, out_ctrl}, 64'd0);
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].iv     = (i < 8);
      tbl[i].ordy   = 1'b1;
      tbl[i].c      = CW'(i * 7 + 1);
      tbl[i].d      = DW'(i + 1);
      tbl[i].exp_ir = 1'b1;
      tbl[i].exp_ov = (i >= 1 && i <= 8);
    end

    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", {54'd0, out_ctrl}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #11 rst_n = 1'b1;

    // Asynchronous reset between edges with a loaded beat.
    drive(1'b1, 1'b0, 1'b0, 10'h3FF, 32'hA5A5A5A5);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("pre_rst_ctrl", {54'd0, out_ctrl}, 64'h3FF);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_ctrl", {54'd0, out_ctrl}, 64'd0);
    chk("arst_out_data", {32'd0, out_data}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #3 rst_n = 1'b1;

    // Streaming 1..8 at full throughput.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, 1'b0, tbl[i].c, tbl[i].d);
      @(negedge clk);
      chk($sformatf("stream_in_ready[%0d]", i), {63'd0, in_ready}, {63'd0, tbl[i].exp_ir});
      chk($sformatf("stream_out_valid[%0d]", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_ov});
    end
    chk("stream_stall_cnt", {60'd0, stall_cnt}, 64'd0);

    // Stall counter counts then saturates; flush leaves it alone.
    drive(1'b1, 1'b0, 1'b0, 10'h155, 32'h5555);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    #1 chk("stall_cnt_5", {60'd0, stall_cnt}, 64'd5);
    repeat (15) @(posedge clk);
    #1 chk("stall_cnt_sat", {60'd0, stall_cnt}, 64'd15);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    chk("stall_after_flush", {60'd0, stall_cnt}, 64'd15);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_SKID_EN
    // Backpressure fills the skid entry, then drains in order.
    drive(1'b1, 1'b0, 1'b0, 10'h0A1, 32'hAAAA0001);
    drive(1'b1, 1'b0, 1'b0, 10'h0B2, 32'hBBBB0002);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("skid_in_ready_full", {63'd0, in_ready}, 64'd0);
    chk("skid_hold_data", {32'd0, out_data}, 64'hAAAA0001);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    chk("skid_in_ready_free", {63'd0, in_ready}, 64'd1);
    chk("skid_second_data", {32'd0, out_data}, 64'hBBBB0002);
    drive(1'b0, 1'b1, 1'b0, '0, '0);

    // Flush in TWO with C offered on the flush cycle.
    drive(1'b1, 1'b0, 1'b0, 10'h0A3, 32'hAAAA0003);
    drive(1'b1, 1'b0, 1'b0, 10'h0B4, 32'hBBBB0004);
    drive(1'b1, 1'b0, 1'b1, 10'h0C5, 32'hCCCC0005);
`else
    // Full stage: in_ready follows out_ready combinationally.
    drive(1'b1, 1'b0, 1'b0, 10'h0A1, 32'hAAAA0001);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("ns_in_ready_lo", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1 chk("ns_in_ready_hi", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
    #1 chk("ns_in_ready_lo2", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 10'h0B2, 32'hBBBB0002);
    drive(1'b1, 1'b1, 1'b0, 10'h0C3, 32'hCCCC0003);
    chk("ns_b2b_valid", {63'd0, out_valid}, 64'd1);
    chk("ns_b2b_data", {32'd0, out_data}, 64'hBBBB0002);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    chk("ns_b2b_data2", {32'd0, out_data}, 64'hCCCC0003);

    // Flush in ONE with C offered while in_ready=1.
    drive(1'b1, 1'b0, 1'b0, 10'h0A3, 32'hAAAA0004);
    drive(1'b1, 1'b1, 1'b1, 10'h0C5, 32'hCCCC0005);
`endif
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    chk("flush2_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush2_out_ctrl", {54'd0, out_ctrl}, 64'd0);
    chk("flush2_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, '0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
